// File: rtl/uart_rx_error_ctrl.sv
// uart_rx_error_ctrl: sequences the RX error manager. It captures the manager's sticky
// error flags, acknowledges them with a one-cycle error_clear strobe, and keeps sticky
// status, saturating per-type counters and the IRQ. After a break it holds the receiver
// off until the line has been idle for RECOVER_BITS bit periods.
module uart_rx_error_ctrl #(
  parameter int RECOVER_BITS = 10,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 framing_error,
  input  logic                 parity_err,
  input  logic                 break_detect,
  input  logic                 timeout_detect,
  input  logic                 rx_filtered,
  input  logic                 bit_tick,
  input  logic [3:0]           err_enable,
  input  logic [3:0]           irq_mask,
  input  logic                 status_rd,
  input  logic                 cnt_clr,
  output logic                 error_clear,
  output logic                 rx_enable,
  output logic [3:0]           err_status,
  output logic [CNT_WIDTH-1:0] frame_err_cnt,
  output logic [CNT_WIDTH-1:0] parity_err_cnt,
  output logic [CNT_WIDTH-1:0] break_cnt,
  output logic                 irq,
  output logic                 busy
);

  localparam int IW = $clog2(RECOVER_BITS + 1);
  localparam logic [IW-1:0]        IDLE_LAST = IW'(RECOVER_BITS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {IDLE, CAPTURE, CLEAR, DRAIN, RECOVER} state_e;

  state_e                          state_q, state_d;
  logic [IW-1:0]                   idle_cnt_q, idle_cnt_d;
  logic                            snap_brk_q, snap_brk_d;
  logic [3:0]                      err_status_q, err_status_d;
  logic [2:0][CNT_WIDTH-1:0]       cnt_q, cnt_d;    // {break, parity, framing}
  logic                            error_clear_q, error_clear_d;
  logic                            rx_enable_q, rx_enable_d;
  logic                            irq_q, irq_d;
  logic                            busy_q, busy_d;
  logic [3:0]                      err_vec;
  logic [3:0]                      capture;

  assign err_vec = {timeout_detect, break_detect, parity_err, framing_error} & err_enable;

  // Next-state, capture, counters and registered-output computation
  always_comb begin
    state_d       = state_q;
    idle_cnt_d    = '0;
    snap_brk_d    = snap_brk_q;
    cnt_d         = cnt_q;
    error_clear_d = 1'b0;
    capture       = '0;
    case (state_q)
      IDLE:    if (|err_vec) state_d = CAPTURE;
      CAPTURE: begin
        capture       = err_vec;
        snap_brk_d    = err_vec[2];
        error_clear_d = 1'b1;          // strobe is high during the CLEAR cycle
        state_d       = CLEAR;
      end
      CLEAR:   state_d = DRAIN;
      // Give the manager one cycle to drop its flags before looking again
      DRAIN:   state_d = snap_brk_q ? RECOVER : IDLE;
      RECOVER: begin
        if (!rx_filtered) begin
          idle_cnt_d = '0;
        end else if (bit_tick) begin
          if (idle_cnt_q == IDLE_LAST) state_d = IDLE;
          else idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // A capture coinciding with a read survives; only previously held bits clear
    err_status_d = (status_rd ? 4'b0000 : err_status_q) | capture;
    for (int i = 0; i < 3; i++) begin
      if (cnt_clr) cnt_d[i] = '0;
      else if (capture[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
    end
    rx_enable_d = (state_d != RECOVER);
    busy_d      = (state_d != IDLE);
    irq_d       = |(err_status_q & irq_mask);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idle_cnt_q    <= '0;
      snap_brk_q    <= 1'b0;
      err_status_q  <= '0;
      cnt_q         <= '0;
      error_clear_q <= 1'b0;
      rx_enable_q   <= 1'b1;
      irq_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      snap_brk_q    <= snap_brk_d;
      err_status_q  <= err_status_d;
      cnt_q         <= cnt_d;
      error_clear_q <= error_clear_d;
      rx_enable_q   <= rx_enable_d;
      irq_q         <= irq_d;
      busy_q        <= busy_d;
    end
  end

  assign error_clear    = error_clear_q;
  assign rx_enable      = rx_enable_q;
  assign err_status     = err_status_q;
  assign frame_err_cnt  = cnt_q[0];
  assign parity_err_cnt = cnt_q[1];
  assign break_cnt      = cnt_q[2];
  assign irq            = irq_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_uart_rx_error_ctrl.sv
// Bench for uart_rx_error_ctrl: directed vector table plus hand-written multi-cycle
// sequences. A tiny error-manager model drops the sticky flags on error_clear.
module tb_uart_rx_error_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] flg;            // {timeout, break, parity, framing}
  logic       rx_filtered, bit_tick, status_rd, cnt_clr;
  logic [3:0] err_enable, irq_mask;
  logic       error_clear, rx_enable, irq, busy;
  logic [3:0] err_status;
  logic [7:0] frame_err_cnt, parity_err_cnt, break_cnt;

  int errs = 0;
  int checks = 0;

  uart_rx_error_ctrl #(.RECOVER_BITS(10), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .framing_error(flg[0]), .parity_err(flg[1]), .break_detect(flg[2]), .timeout_detect(flg[3]),
    .rx_filtered(rx_filtered), .bit_tick(bit_tick),
    .err_enable(err_enable), .irq_mask(irq_mask),
    .status_rd(status_rd), .cnt_clr(cnt_clr),
    .error_clear(error_clear), .rx_enable(rx_enable), .err_status(err_status),
    .frame_err_cnt(frame_err_cnt), .parity_err_cnt(parity_err_cnt), .break_cnt(break_cnt),
    .irq(irq), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] flags, en, mask;
    logic [3:0] st;
    int         fc, pc, bc;
    logic       irq;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock; the manager model drops its flags on the edge that sees error_clear
  task automatic step();
    logic ec;
    ec = error_clear;
    @(posedge clk);
    #1;
    if (ec) flg = 4'b0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flg   = 4'b0000;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int ecn;
    rst_n = 1'b0; flg = '0; rx_filtered = 1'b1; bit_tick = 1'b0;
    status_rd = 1'b0; cnt_clr = 1'b0; err_enable = 4'hF; irq_mask = 4'h0;

    tbl[0] = '{flags:4'b0001, en:4'hF,    mask:4'b0001, st:4'b0001, fc:1, pc:0, bc:0, irq:1'b1};
    tbl[1] = '{flags:4'b0011, en:4'hF,    mask:4'b0000, st:4'b0011, fc:2, pc:1, bc:0, irq:1'b0};
    tbl[2] = '{flags:4'b1000, en:4'hF,    mask:4'b1000, st:4'b1000, fc:2, pc:1, bc:0, irq:1'b1};
    tbl[3] = '{flags:4'b0010, en:4'b1101, mask:4'hF,    st:4'b0000, fc:2, pc:1, bc:0, irq:1'b0};
    tbl[4] = '{flags:4'b0001, en:4'b1101, mask:4'b0010, st:4'b0001, fc:3, pc:1, bc:0, irq:1'b0};
    tbl[5] = '{flags:4'b0010, en:4'hF,    mask:4'b0010, st:4'b0010, fc:3, pc:2, bc:0, irq:1'b1};

    #12;
    chk("rst error_clear", error_clear, 0);
    chk("rst rx_enable", rx_enable, 1);
    chk("rst err_status", err_status, 0);
    chk("rst frame_cnt", frame_err_cnt, 0);
    chk("rst parity_cnt", parity_err_cnt, 0);
    chk("rst break_cnt", break_cnt, 0);
    chk("rst irq", irq, 0);
    chk("rst busy", busy, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Vector table: read-clear status, raise flags, let the sequence finish, compare
    for (int i = 0; i < 6; i++) begin
      status_rd = 1'b1; step(); status_rd = 1'b0;
      err_enable = tbl[i].en;
      irq_mask   = tbl[i].mask;
      flg        = flg | tbl[i].flags;
      repeat (6) step();
      chk($sformatf("vec%0d err_status", i), err_status, tbl[i].st);
      chk($sformatf("vec%0d frame_cnt", i), frame_err_cnt, tbl[i].fc);
      chk($sformatf("vec%0d parity_cnt", i), parity_err_cnt, tbl[i].pc);
      chk($sformatf("vec%0d break_cnt", i), break_cnt, tbl[i].bc);
      chk($sformatf("vec%0d irq", i), irq, tbl[i].irq);
      chk($sformatf("vec%0d busy", i), busy, 0);
    end

    // Latency of a single framing error
    do_reset();
    err_enable = 4'hF; irq_mask = 4'b0001;
    flg = 4'b0001;
    step();
    chk("lat busy c1", busy, 1);
    chk("lat status c1", err_status, 0);
    chk("lat clear c1", error_clear, 0);
    step();
    chk("lat status c2", err_status, 4'b0001);
    chk("lat fcnt c2", frame_err_cnt, 1);
    chk("lat clear c2", error_clear, 1);
    chk("lat irq c2", irq, 0);
    step();
    chk("lat clear c3", error_clear, 0);
    chk("lat irq c3", irq, 1);
    chk("lat busy c3", busy, 1);
    step();
    chk("lat busy c4", busy, 0);
    step();
    chk("lat fcnt final", frame_err_cnt, 1);

    // Two errors in one cycle, single clear, then read-to-clear
    status_rd = 1'b1; step(); status_rd = 1'b0;
    irq_mask = 4'b0011;
    flg = 4'b0011;
    ecn = 0;
    repeat (6) begin step(); ecn += int'(error_clear); end
    chk("dual clear pulses", ecn, 1);
    chk("dual status", err_status, 4'b0011);
    chk("dual fcnt", frame_err_cnt, 2);
    chk("dual pcnt", parity_err_cnt, 1);
    chk("dual irq", irq, 1);
    status_rd = 1'b1; step(); status_rd = 1'b0;
    chk("rd status", err_status, 0);
    step();
    chk("rd irq", irq, 0);

    // status_rd in the CAPTURE cycle keeps the new capture only
    flg = 4'b0001;
    repeat (6) step();
    chk("pre rd status", err_status, 4'b0001);
    flg = flg | 4'b0010;
    step();
    status_rd = 1'b1; step(); status_rd = 1'b0;
    chk("rd+cap status", err_status, 4'b0010);
    chk("rd+cap pcnt", parity_err_cnt, 2);
    repeat (4) step();

    // Break recovery
    do_reset();
    rx_filtered = 1'b1;
    flg = 4'b0100;
    repeat (4) step();
    chk("brk rx_enable", rx_enable, 0);
    chk("brk cnt", break_cnt, 1);
    chk("brk busy", busy, 1);
    repeat (9) begin bit_tick = 1'b1; step(); bit_tick = 1'b0; step(); end
    rx_filtered = 1'b0; step(); rx_filtered = 1'b1;
    chk("brk after low", rx_enable, 0);
    repeat (9) begin bit_tick = 1'b1; step(); bit_tick = 1'b0; step(); end
    chk("brk 9 ticks", rx_enable, 0);
    bit_tick = 1'b1; step(); bit_tick = 1'b0;
    chk("brk 10 ticks", rx_enable, 1);
    chk("brk idle busy", busy, 0);

    // Asynchronous reset in the middle of break recovery
    flg = 4'b0101;
    repeat (4) step();
    chk("pre-rst rx_enable", rx_enable, 0);
    rst_n = 1'b0; flg = 4'b0000;
    #2;
    chk("midrst rx_enable", rx_enable, 1);
    chk("midrst status", err_status, 0);
    chk("midrst fcnt", frame_err_cnt, 0);
    chk("midrst bcnt", break_cnt, 0);
    chk("midrst busy", busy, 0);
    chk("midrst clear", error_clear, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Counter saturation and cnt_clr priority
    for (int n = 0; n < 255; n++) begin flg = 4'b0001; repeat (4) step(); end
    chk("sat 255", frame_err_cnt, 255);
    flg = 4'b0001; repeat (4) step();
    chk("sat hold", frame_err_cnt, 255);
    chk("sat pcnt", parity_err_cnt, 0);
    flg = 4'b0001;
    step();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("clr wins", frame_err_cnt, 0);
    chk("clr status", err_status, 4'b0001);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
